// File: rtl/ppgen_serial_if.sv
// ----------------------------------------------------------------------------
// ppgen_serial_if
//   Bundles the operand-in and row-beat-out handshakes of ppgen_serial.
//   Parameters DW (operand width / row count) and RPC (rows per beat) must
//   match the attached ppgen_serial instance.
//   Signals:
//     in_valid / in_ready       operand pair handshake
//     in_muld, in_mulr          multiplicand, multiplier (DW bits each)
//     in_signed                 1 = Baugh-Wooley signed rows
//     out_valid / out_ready     row beat handshake
//     out_rows                  RPC rows of DW bits, lowest row in low bits
//     out_row_idx               index of first row carried by the beat
//     out_last                  final beat of the operation
//     out_signed                signed flag captured with the operands
//   Modports:
//     master  - operand producer / beat consumer (testbench, upstream logic)
//     slave   - the partial-product generator itself
// ----------------------------------------------------------------------------
interface ppgen_serial_if #(
    parameter int DW  = 8,
    parameter int RPC = 2
) ();
    localparam int IDXW = (DW > 1) ? $clog2(DW) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_muld;
    logic [DW-1:0]         in_mulr;
    logic                  in_signed;
    logic                  out_valid;
    logic                  out_ready;
    logic [RPC*DW-1:0]     out_rows;
    logic [IDXW-1:0]       out_row_idx;
    logic                  out_last;
    logic                  out_signed;

    modport master (
        output in_valid, in_muld, in_mulr, in_signed, out_ready,
        input  in_ready, out_valid, out_rows, out_row_idx, out_last, out_signed
    );

    modport slave (
        input  in_valid, in_muld, in_mulr, in_signed, out_ready,
        output in_ready, out_valid, out_rows, out_row_idx, out_last, out_signed
    );
endinterface

// File: rtl/ppgen_serial.sv
// ----------------------------------------------------------------------------
// ppgen_serial
//   Row-serial partial-product generator. Captures one muld/mulr pair and
//   emits its DW partial-product rows, RPC rows per beat, over DW/RPC beats.
//   Supports Baugh-Wooley signed rows (downstream adds 2^DW + 2^(2DW-1))
//   and approximate truncation of columns 0..TRUNC-1.
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous reset, active-high
//     bus   ppgen_serial_if.slave (operand in / row beat out handshakes)
// ----------------------------------------------------------------------------
module ppgen_serial #(
    parameter int DW    = 8,
    parameter int RPC   = 2,
    parameter int TRUNC = 0
) (
    input  logic           clk,
    input  logic           rst,
    ppgen_serial_if.slave  bus
);
    localparam int NBEATS = DW / RPC;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int IDXW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    generate
        if ((DW % RPC) != 0) begin : g_bad_rpc
            $error("ppgen_serial: RPC must divide DW");
        end
        if ($bits(bus.in_muld) != DW || $bits(bus.out_rows) != RPC * DW) begin : g_bad_if
            $error("ppgen_serial: interface parameters do not match DW/RPC");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [DW-1:0]   muld_q, mulr_q;
    logic            signed_q;
    logic            load;
    logic            in_ready;
    logic            out_valid;
    logic            out_last;
    logic [IDXW-1:0] row_base;
    logic [RPC*DW-1:0] rows;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            muld_q   <= '0;
            mulr_q   <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (load) begin
                muld_q   <= bus.in_muld;
                mulr_q   <= bus.in_mulr;
                signed_q <= bus.in_signed;
            end
        end
    end

    assign out_last = (state_q == S_EMIT) && (beat_q == LAST_BEAT);

    // ------------------------------------------------------------------
    // Next-state / handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    beat_d  = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (out_last) begin
                        // Last beat leaving: take the next op in the same
                        // cycle so back-to-back ops have no bubble.
                        in_ready = 1'b1;
                        beat_d   = '0;
                        if (bus.in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row generation from registered operands only
    // ------------------------------------------------------------------
    assign row_base = IDXW'(int'(beat_q) * RPC);

    generate
        for (genvar gi = 0; gi < RPC; gi++) begin : g_row
            logic [IDXW-1:0] row_k;
            logic            is_top;
            logic            sel;

            assign row_k  = row_base + IDXW'(gi);
            assign is_top = (row_k == IDXW'(DW - 1));
            assign sel    = mulr_q[row_k];

            for (genvar gj = 0; gj < DW; gj++) begin : g_bit
                localparam logic MSB_COL = (gj == DW - 1);
                logic pp;
                logic inv;
                logic keep;

                assign pp   = sel & muld_q[gj];
                // Baugh-Wooley: invert the MSB column of every row except
                // the top one, and every non-MSB column of the top row.
                // The (top, MSB) corner stays plain.
                assign inv  = signed_q & (is_top ^ MSB_COL);
                // Truncation acts on the final bit value, after inversion.
                assign keep = (int'(row_k) + gj) >= TRUNC;
                assign rows[DW*gi+gj] = (pp ^ inv) & keep;
            end
        end
    endgenerate

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_rows    = out_valid ? rows : '0;
    assign bus.out_row_idx = row_base;
    assign bus.out_last    = out_last;
    assign bus.out_signed  = signed_q;

endmodule

// File: tb/tb_ppgen_serial.sv
module tb_ppgen_serial;
    localparam int DW  = 8;
    localparam int RPC = 2;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    ppgen_serial_if #(.DW(DW), .RPC(RPC)) if_a ();
    ppgen_serial_if #(.DW(DW), .RPC(RPC)) if_t ();

    ppgen_serial #(.DW(DW), .RPC(RPC), .TRUNC(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    ppgen_serial #(.DW(DW), .RPC(RPC), .TRUNC(4)) u_dut_t (
        .clk (clk),
        .rst (rst),
        .bus (if_t.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair while the DUT is idle; returns with beat 0 visible.
    task automatic start_op(input logic [7:0] md, input logic [7:0] mr, input logic sg);
        if_a.in_valid  = 1'b1;
        if_a.in_muld   = md;
        if_a.in_mulr   = mr;
        if_a.in_signed = sg;
        tick();
        if_a.in_valid  = 1'b0;
        if_a.in_muld   = 8'h00;
        if_a.in_mulr   = 8'h00;
        if_a.in_signed = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vec_cnt++;
        if (if_a.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL reset_in_ready got=%b want=1", if_a.in_ready);
        end
        vec_cnt++;
        if (if_a.out_valid !== 1'b0 || if_a.out_last !== 1'b0 || if_a.out_signed !== 1'b0) begin
            err_cnt++; $display("FAIL reset_outs got v=%b l=%b s=%b want 0,0,0",
                                if_a.out_valid, if_a.out_last, if_a.out_signed);
        end
        vec_cnt++;
        if (if_a.out_rows !== 16'h0000 || if_a.out_row_idx !== 3'd0) begin
            err_cnt++; $display("FAIL reset_rows got rows=%h idx=%0d want 0000,0",
                                if_a.out_rows, if_a.out_row_idx);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_unsigned();
        logic [15:0] exp_r [4];
        logic [31:0] sum;
        exp_r = '{16'hB5B5, 16'hB5B5, 16'h0000, 16'h0000};
        sum = 0;
        if_a.out_ready = 1'b1;
        start_op(8'hB5, 8'h0F, 1'b0);
        for (int b = 0; b < 4; b++) begin
            vec_cnt++;
            if (if_a.out_valid !== 1'b1 || if_a.out_row_idx !== 3'(2*b)) begin
                err_cnt++; $display("FAIL uns_beat%0d got v=%b idx=%0d want 1,%0d",
                                    b, if_a.out_valid, if_a.out_row_idx, 2*b);
            end
            vec_cnt++;
            if (if_a.out_rows !== exp_r[b] || if_a.out_last !== (b == 3)) begin
                err_cnt++; $display("FAIL uns_rows%0d got rows=%h last=%b want %h,%b",
                                    b, if_a.out_rows, if_a.out_last, exp_r[b], (b == 3));
            end
            for (int k = 0; k < RPC; k++)
                sum += 32'(if_a.out_rows[DW*k +: DW]) << (int'(if_a.out_row_idx) + k);
            tick();
        end
        vec_cnt++;
        if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL uns_idle got v=%b rdy=%b want 0,1", if_a.out_valid, if_a.in_ready);
        end
        vec_cnt++;
        if (sum !== 32'h0A9B) begin
            err_cnt++; $display("FAIL uns_sum got=%h want=00000a9b", sum);
        end
        $display("op unsigned B5*0F sum=%h", sum);
    endtask

    task automatic test_stall();
        if_a.out_ready = 1'b1;
        start_op(8'hB5, 8'h0F, 1'b0);
        tick();                      // now on beat 1
        if_a.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vec_cnt++;
            if (if_a.out_valid !== 1'b1 || if_a.out_rows !== 16'hB5B5 ||
                if_a.out_row_idx !== 3'd2 || if_a.in_ready !== 1'b0) begin
                err_cnt++; $display("FAIL stall_c%0d got v=%b rows=%h idx=%0d rdy=%b want 1,b5b5,2,0",
                                    c, if_a.out_valid, if_a.out_rows, if_a.out_row_idx, if_a.in_ready);
            end
            tick();
        end
        if_a.out_ready = 1'b1;
        tick();                      // beat 2
        vec_cnt++;
        if (if_a.out_row_idx !== 3'd4 || if_a.out_rows !== 16'h0000) begin
            err_cnt++; $display("FAIL stall_resume got idx=%0d rows=%h want 4,0000",
                                if_a.out_row_idx, if_a.out_rows);
        end
        tick();                      // beat 3
        vec_cnt++;
        if (if_a.out_last !== 1'b1 || if_a.out_row_idx !== 3'd6) begin
            err_cnt++; $display("FAIL stall_last got last=%b idx=%0d want 1,6", if_a.out_last, if_a.out_row_idx);
        end
        tick();
        vec_cnt++;
        if (if_a.out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL stall_idle got v=%b want 0", if_a.out_valid);
        end
        $display("op stalled B5*0F done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_r [4];
        logic [31:0] sum;
        exp_r = '{16'h003C, 16'h0000, 16'h0000, 16'h3C00};
        sum = 0;
        if_a.out_ready = 1'b1;
        start_op(8'hB5, 8'h0F, 1'b0);
        tick(); tick(); tick();      // beat 3 of op A
        if_a.in_valid = 1'b1;
        if_a.in_muld  = 8'h3C;
        if_a.in_mulr  = 8'h81;
        vec_cnt++;
        if (if_a.out_last !== 1'b1 || if_a.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL b2b_handoff got last=%b rdy=%b want 1,1", if_a.out_last, if_a.in_ready);
        end
        tick();
        if_a.in_valid = 1'b0;
        if_a.in_muld  = 8'h00;
        if_a.in_mulr  = 8'h00;
        for (int b = 0; b < 4; b++) begin
            vec_cnt++;
            if (if_a.out_valid !== 1'b1 || if_a.out_row_idx !== 3'(2*b) || if_a.out_rows !== exp_r[b]) begin
                err_cnt++; $display("FAIL b2b_beat%0d got v=%b idx=%0d rows=%h want 1,%0d,%h",
                                    b, if_a.out_valid, if_a.out_row_idx, if_a.out_rows, 2*b, exp_r[b]);
            end
            for (int k = 0; k < RPC; k++)
                sum += 32'(if_a.out_rows[DW*k +: DW]) << (int'(if_a.out_row_idx) + k);
            tick();
        end
        vec_cnt++;
        if (sum !== 32'h1E3C || if_a.out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL b2b_sum got sum=%h v=%b want 00001e3c,0", sum, if_a.out_valid);
        end
        $display("op back-to-back 3C*81 sum=%h", sum);
    endtask

    task automatic test_signed(input logic [7:0] md, input logic [7:0] mr,
                               input logic [63:0] exp_beats, input logic [15:0] exp_prod);
        logic [31:0] sum;
        logic [15:0] prod;
        sum = 0;
        if_a.out_ready = 1'b1;
        start_op(md, mr, 1'b1);
        for (int b = 0; b < 4; b++) begin
            vec_cnt++;
            if (if_a.out_rows !== exp_beats[16*b +: 16] || if_a.out_signed !== 1'b1 ||
                if_a.out_row_idx !== 3'(2*b)) begin
                err_cnt++; $display("FAIL sgn_%h_%h_beat%0d got rows=%h s=%b idx=%0d want %h,1,%0d",
                                    md, mr, b, if_a.out_rows, if_a.out_signed, if_a.out_row_idx,
                                    exp_beats[16*b +: 16], 2*b);
            end
            for (int k = 0; k < RPC; k++)
                sum += 32'(if_a.out_rows[DW*k +: DW]) << (int'(if_a.out_row_idx) + k);
            tick();
        end
        prod = sum[15:0] + 16'h8100;
        vec_cnt++;
        if (prod !== exp_prod) begin
            err_cnt++; $display("FAIL sgn_%h_%h_prod got=%h want=%h", md, mr, prod, exp_prod);
        end
        $display("op signed %h*%h product=%h", md, mr, prod);
    endtask

    task automatic test_trunc();
        logic [15:0] exp_r [4];
        exp_r = '{16'hF8F0, 16'hFEFC, 16'hFFFF, 16'hFFFF};
        if_t.out_ready = 1'b1;
        if_t.in_valid  = 1'b1;
        if_t.in_muld   = 8'hFF;
        if_t.in_mulr   = 8'hFF;
        if_t.in_signed = 1'b0;
        tick();
        if_t.in_valid  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            vec_cnt++;
            if (if_t.out_valid !== 1'b1 || if_t.out_rows !== exp_r[b]) begin
                err_cnt++; $display("FAIL trunc_beat%0d got v=%b rows=%h want 1,%h",
                                    b, if_t.out_valid, if_t.out_rows, exp_r[b]);
            end
            tick();
        end
        $display("op trunc4 FF*FF done");
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_r [4];
        exp_r = '{16'h003C, 16'h0000, 16'h0000, 16'h3C00};
        if_a.out_ready = 1'b1;
        start_op(8'hB5, 8'h0F, 1'b0);
        tick(); tick();              // beat 2
        vec_cnt++;
        if (if_a.out_row_idx !== 3'd4 || if_a.out_valid !== 1'b1) begin
            err_cnt++; $display("FAIL rstmid_pre got idx=%0d v=%b want 4,1", if_a.out_row_idx, if_a.out_valid);
        end
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1 || if_a.out_row_idx !== 3'd0) begin
            err_cnt++; $display("FAIL rstmid_async got v=%b rdy=%b idx=%0d want 0,1,0",
                                if_a.out_valid, if_a.in_ready, if_a.out_row_idx);
        end
        tick();
        rst = 1'b0;
        tick();
        vec_cnt++;
        if (if_a.out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_replay got v=%b want 0", if_a.out_valid);
        end
        start_op(8'h3C, 8'h81, 1'b0);
        for (int b = 0; b < 4; b++) begin
            vec_cnt++;
            if (if_a.out_valid !== 1'b1 || if_a.out_row_idx !== 3'(2*b) || if_a.out_rows !== exp_r[b]) begin
                err_cnt++; $display("FAIL rstmid_beat%0d got v=%b idx=%0d rows=%h want 1,%0d,%h",
                                    b, if_a.out_valid, if_a.out_row_idx, if_a.out_rows, 2*b, exp_r[b]);
            end
            tick();
        end
        $display("op after mid-reset 3C*81 done");
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_muld = '0; if_a.in_mulr = '0;
        if_a.in_signed = 1'b0; if_a.out_ready = 1'b1;
        if_t.in_valid = 1'b0; if_t.in_muld = '0; if_t.in_mulr = '0;
        if_t.in_signed = 1'b0; if_t.out_ready = 1'b1;

        test_reset();
        test_unsigned();
        test_stall();
        test_back_to_back();
        test_signed(8'h80, 8'hFF, 64'hFF00_0000_0000_0000, 16'h0080);
        test_signed(8'h05, 8'h03, 64'h7F80_8080_8080_8585, 16'h000F);
        test_trunc();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
